// File: rtl/mode_select_fsm.sv
// Main-menu mode selector for N game modes: qualified key selection, release handshakes,
// registered mode bus with enter/exit strobes. Optional idle auto-exit under `MODE_TIMEOUT_EN.
module mode_select_fsm #(
    parameter int NUM_MODES      = 2,
    parameter int MODE_W         = 2,
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 iReset,
    input  logic [NUM_MODES-1:0] iSel,
    input  logic                 iBack,
    input  logic                 iDone,
    output logic [MODE_W-1:0]    oMode,
    output logic                 oEnter,
    output logic                 oExit
);

    localparam int SEL_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int HOLD_W = 16;

    // Elaboration-time parameter sanity checks.
    if (NUM_MODES < 1 || NUM_MODES > 15) begin : g_bad_num_modes
        $error("NUM_MODES out of range");
    end
    if ((1 << MODE_W) < NUM_MODES + 1) begin : g_bad_mode_w
        $error("MODE_W too narrow for NUM_MODES");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
        $error("HOLD_CYCLES out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [1:0] {
        S_MENU      = 2'd0,
        S_ARM       = 2'd1,
        S_ACTIVE    = 2'd2,
        S_EXIT_WAIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]    prev_cand_q, prev_cand_d;
    logic                prev_valid_q, prev_valid_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic                enter_q, enter_d;
    logic                exit_q, exit_d;

    logic [SEL_W-1:0]    cand;
    logic                cand_valid;
    logic [MODE_W-1:0]   mode_code;
    logic                timeout_hit;

    // Lowest-index pressed key wins when several are held together.
    always_comb begin
        cand       = '0;
        cand_valid = |iSel;
        for (int k = NUM_MODES - 1; k >= 0; k--) begin
            if (iSel[k]) cand = SEL_W'(k);
        end
    end

    assign mode_code = MODE_W'(sel_q) + MODE_W'(1);

`ifdef MODE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_next;

    always_comb begin
        tmo_next    = '0;
        timeout_hit = 1'b0;
        if (state_q == S_ACTIVE) begin
            if ((iSel != '0) || iDone) tmo_next = '0;
            else                       tmo_next = tmo_cnt_q + TMO_W'(1);
            timeout_hit = (tmo_next == TMO_W'(TIMEOUT_CYCLES));
        end
    end

    // Counter only lives while ACTIVE; it is zero on the entry edge and after any exit.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_d == S_ACTIVE) tmo_cnt_d = tmo_next;
    end

    always_ff @(posedge clk) begin
        if (iReset) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = '0;
        prev_cand_d  = cand;
        prev_valid_d = 1'b0;
        sel_d        = sel_q;
        mode_d       = '0;
        enter_d      = 1'b0;
        exit_d       = 1'b0;

        case (state_q)
            S_MENU: begin
                prev_valid_d = cand_valid;
                if (!cand_valid) begin
                    hold_cnt_d = '0;
                end else if (prev_valid_q && (cand == prev_cand_q)) begin
                    hold_cnt_d = (hold_cnt_q == {HOLD_W{1'b1}}) ? hold_cnt_q
                                                                 : hold_cnt_q + HOLD_W'(1);
                end else begin
                    hold_cnt_d = HOLD_W'(1);
                end
                if (cand_valid && (hold_cnt_d >= HOLD_W'(HOLD_CYCLES))) begin
                    sel_d        = cand;
                    state_d      = S_ARM;
                    hold_cnt_d   = '0;
                    prev_valid_d = 1'b0;
                end
            end
            S_ARM: begin
                // Back aborts before the game ever starts, so no strobes fire.
                if (iBack) begin
                    state_d = S_EXIT_WAIT;
                end else if (iSel == '0) begin
                    state_d = S_ACTIVE;
                    mode_d  = mode_code;
                    enter_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                mode_d = mode_code;
                if (iBack || iDone || timeout_hit) begin
                    state_d = S_EXIT_WAIT;
                    mode_d  = '0;
                    exit_d  = 1'b1;
                end
            end
            S_EXIT_WAIT: begin
                if (!iBack) state_d = S_MENU;
            end
            default: begin
                state_d = S_MENU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q      <= S_MENU;
            hold_cnt_q   <= '0;
            prev_cand_q  <= '0;
            prev_valid_q <= 1'b0;
            sel_q        <= '0;
            mode_q       <= '0;
            enter_q      <= 1'b0;
            exit_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            prev_cand_q  <= prev_cand_d;
            prev_valid_q <= prev_valid_d;
            sel_q        <= sel_d;
            mode_q       <= mode_d;
            enter_q      <= enter_d;
            exit_q       <= exit_d;
        end
    end

    assign oMode  = mode_q;
    assign oEnter = enter_q;
    assign oExit  = exit_q;

endmodule

// File: tb/tb_mode_select_fsm.sv
// Directed bench for mode_select_fsm: one instance with HOLD_CYCLES=1, one with HOLD_CYCLES=3.
module tb_mode_select_fsm;

    logic       clk;
    logic       a_rst, a_back, a_done, a_enter, a_exit;
    logic [1:0] a_sel, a_mode;
    logic       b_rst, b_back, b_done, b_enter, b_exit;
    logic [1:0] b_sel, b_mode;

    int total;
    int bad;

    mode_select_fsm #(.NUM_MODES(2), .MODE_W(2), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(10)) u_a (
        .clk(clk), .iReset(a_rst), .iSel(a_sel), .iBack(a_back), .iDone(a_done),
        .oMode(a_mode), .oEnter(a_enter), .oExit(a_exit)
    );

    mode_select_fsm #(.NUM_MODES(2), .MODE_W(2), .HOLD_CYCLES(3), .TIMEOUT_CYCLES(10)) u_b (
        .clk(clk), .iReset(b_rst), .iSel(b_sel), .iBack(b_back), .iDone(b_done),
        .oMode(b_mode), .oEnter(b_enter), .oExit(b_exit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [1:0] m, input logic en, input logic ex);
        check({tag, "_mode"}, 32'(a_mode), 32'(m));
        check({tag, "_enter"}, 32'(a_enter), 32'(en));
        check({tag, "_exit"}, 32'(a_exit), 32'(ex));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        a_rst = 1'b1; a_sel = 2'b00; a_back = 1'b0; a_done = 1'b0;
        b_rst = 1'b1; b_sel = 2'b00; b_back = 1'b0; b_done = 1'b0;
        step();
        step();
        check_a("a_reset", 2'd0, 1'b0, 1'b0);
        check("b_reset_mode", 32'(b_mode), 32'd0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Hold key 0 for three cycles: ARM immediately, nothing visible until release.
        a_sel = 2'b01;
        step();
        check_a("a_arm1", 2'd0, 1'b0, 1'b0);
        step();
        step();
        check_a("a_arm3", 2'd0, 1'b0, 1'b0);
        a_sel = 2'b00;
        step();
        check_a("a_enter_m1", 2'd1, 1'b1, 1'b0);
        step();
        check_a("a_active_m1", 2'd1, 1'b0, 1'b0);

        a_back = 1'b1;
        step();
        check_a("a_back_exit", 2'd0, 1'b0, 1'b1);
        a_back = 1'b0;
        step();
        check_a("a_back_menu", 2'd0, 1'b0, 1'b0);

        // Both keys: lowest index wins.
        a_sel = 2'b11;
        step();
        step();
        a_sel = 2'b00;
        step();
        check_a("a_both_keys", 2'd1, 1'b1, 1'b0);

        // Single-cycle iDone, then MENU exactly one cycle after EXIT_WAIT.
        a_done = 1'b1;
        step();
        check_a("a_done_exit", 2'd0, 1'b0, 1'b1);
        a_done = 1'b0;
        step();
        a_sel = 2'b10;
        step();
        a_sel = 2'b00;
        step();
        check_a("a_enter_m2", 2'd2, 1'b1, 1'b0);

        // Selection keys ignored in ACTIVE.
        a_sel = 2'b01;
        step();
        check_a("a_active_sel", 2'd2, 1'b0, 1'b0);
        a_sel = 2'b00;

        // Back held 4 cycles; iSel pulse in EXIT_WAIT does nothing.
        a_back = 1'b1;
        step();
        check_a("a_back4_e1", 2'd0, 1'b0, 1'b1);
        step();
        check_a("a_back4_e2", 2'd0, 1'b0, 1'b0);
        a_sel = 2'b01;
        step();
        a_sel = 2'b00;
        step();
        check_a("a_back4_e4", 2'd0, 1'b0, 1'b0);
        a_back = 1'b0;
        step();
        check_a("a_back4_rel", 2'd0, 1'b0, 1'b0);
        a_sel = 2'b01;
        step();
        a_sel = 2'b00;
        step();
        check_a("a_after_back4", 2'd1, 1'b1, 1'b0);

        a_back = 1'b1;
        step();
        a_back = 1'b0;
        step();

        // Reset in ARM returns to MENU and discards the latched selection.
        a_sel = 2'b10;
        step();
        a_rst = 1'b1;
        step();
        check_a("a_rst_arm", 2'd0, 1'b0, 1'b0);
        a_rst = 1'b0;
        a_sel = 2'b00;
        step();
        check_a("a_rst_menu", 2'd0, 1'b0, 1'b0);

        // Back held in ARM aborts without any strobe.
        a_sel  = 2'b01;
        step();
        a_back = 1'b1;
        step();
        check_a("a_arm_abort", 2'd0, 1'b0, 1'b0);
        a_sel  = 2'b00;
        a_back = 1'b0;
        step();
        step();
        check_a("a_abort_menu", 2'd0, 1'b0, 1'b0);

        // Enter mode 1 and leave it idle.
        a_sel = 2'b01;
        step();
        a_sel = 2'b00;
        step();
        check_a("a_idle_enter", 2'd1, 1'b1, 1'b0);
`ifdef MODE_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            a_sel = (k == 5) ? 2'b01 : 2'b00;
            step();
            check("tmo_exit", 32'(a_exit), (k == 15) ? 32'd1 : 32'd0);
            check("tmo_mode", 32'(a_mode), (k == 15) ? 32'd0 : 32'd1);
        end
        a_sel = 2'b00;
`else
        for (int k = 1; k <= 100; k++) begin
            step();
            check("idle_exit", 32'(a_exit), 32'd0);
        end
        check("idle_mode", 32'(a_mode), 32'd1);
`endif

        // HOLD_CYCLES=3: two-cycle holds never qualify.
        b_sel = 2'b10;
        step();
        step();
        b_sel = 2'b00;
        step();
        check("b_short1_mode", 32'(b_mode), 32'd0);
        b_sel = 2'b10;
        step();
        step();
        b_sel = 2'b00;
        step();
        check("b_short2_mode", 32'(b_mode), 32'd0);
        check("b_short2_enter", 32'(b_enter), 32'd0);
        step();
        check("b_short3_mode", 32'(b_mode), 32'd0);
        b_sel = 2'b10;
        step();
        step();
        step();
        check("b_hold3_armed", 32'(b_mode), 32'd0);
        b_sel = 2'b00;
        step();
        check("b_hold3_mode", 32'(b_mode), 32'd2);
        check("b_hold3_enter", 32'(b_enter), 32'd1);
        step();
        check("b_hold3_enter_off", 32'(b_enter), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
